score_argmax: RTL and testbench

- Downstream classifier stage: consumes the NUM_CLASS signed 32-bit class scores from the multiply-accumulate array and reduces them to a winning class index and score.
- On a START pulse it walks the score vector one class per cycle through a registered index/select port, so the upstream score mux stays one-cycle.
- Results are held for the CPU interface to read back.

---
 rtl/score_argmax.sv | 211 +++++++++++++++++++++
 tb/tb_score_argmax.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_argmax.sv
// score_argmax: scans NUM_CLASS signed scores one per cycle through a registered index port and
// reports the winning class. Define ARGMAX_TOP2_EN to also track the runner-up on SEC_IDX/SEC_VAL.
`timescale 1ns/1ps

module score_argmax #(
   parameter int NUM_CLASS = 46,
   parameter int DATA_W    = 32,
   parameter int IDX_W     = 6
) (
   input  logic              CLK,
   input  logic              RESET_X,
   input  logic              START,
   output logic [IDX_W-1:0]  SCORE_IDX,
   input  logic [DATA_W-1:0] SCORE,
   output logic              BUSY,
   output logic              DONE,
   output logic [IDX_W-1:0]  MAX_IDX,
   output logic [DATA_W-1:0] MAX_VAL,
   output logic [IDX_W-1:0]  SEC_IDX,
   output logic [DATA_W-1:0] SEC_VAL
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Request index issued in the cycle whose successor is DRAIN.
   localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_CLASS - 2);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [IDX_W-1:0]    max_idx_q, max_idx_d;
   logic [DATA_W-1:0]   max_val_q, max_val_d;
   logic [IDX_W-1:0]    sec_idx_q, sec_idx_d;
   logic [DATA_W-1:0]   sec_val_q, sec_val_d;
   logic [IDX_W-1:0]    wmax_idx_q, wmax_idx_d;
   logic [DATA_W-1:0]   wmax_val_q, wmax_val_d;
   logic                sample_s;
   logic                first_s;
   logic                gt_max_s;
`ifdef ARGMAX_TOP2_EN
   logic [IDX_W-1:0]    wsec_idx_q, wsec_idx_d;
   logic [DATA_W-1:0]   wsec_val_q, wsec_val_d;
   logic                wsec_vld_q, wsec_vld_d;
   logic                gt_sec_s;
`endif

   // State register.
   always_ff @(posedge CLK or negedge RESET_X) begin
      if (!RESET_X) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (idx_q == LAST_REQ) begin
               state_d = DRAIN;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Working max: SCORE always belongs to the index currently on SCORE_IDX.
   always_comb begin
      sample_s   = (state_q == RUN) || (state_q == DRAIN);
      first_s    = (idx_q == {IDX_W{1'b0}});
      gt_max_s   = ($signed(SCORE) > $signed(wmax_val_q));
      wmax_idx_d = wmax_idx_q;
      wmax_val_d = wmax_val_q;
      if (sample_s && (first_s || gt_max_s)) begin
         wmax_idx_d = idx_q;
         wmax_val_d = SCORE;
      end else begin
         wmax_idx_d = wmax_idx_q;
         wmax_val_d = wmax_val_q;
      end
   end

`ifdef ARGMAX_TOP2_EN
   // Working runner-up: demoted max, or a score beating the current second.
   always_comb begin
      gt_sec_s   = ($signed(SCORE) > $signed(wsec_val_q));
      wsec_idx_d = wsec_idx_q;
      wsec_val_d = wsec_val_q;
      wsec_vld_d = wsec_vld_q;
      if (!sample_s) begin
         wsec_vld_d = wsec_vld_q;
      end else if (first_s) begin
         wsec_vld_d = 1'b0;
      end else if (gt_max_s) begin
         wsec_idx_d = wmax_idx_q;
         wsec_val_d = wmax_val_q;
         wsec_vld_d = 1'b1;
      end else if (!wsec_vld_q || gt_sec_s) begin
         wsec_idx_d = idx_q;
         wsec_val_d = SCORE;
         wsec_vld_d = 1'b1;
      end else begin
         wsec_vld_d = wsec_vld_q;
      end
   end
`endif

   // FSM outputs: request index, status flags and result load on the final sample.
   always_comb begin
      idx_d     = idx_q;
      busy_d    = (state_d != IDLE);
      done_d    = (state_q == DRAIN);
      max_idx_d = max_idx_q;
      max_val_d = max_val_q;
      sec_idx_d = sec_idx_q;
      sec_val_d = sec_val_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               idx_d = {IDX_W{1'b0}};
            end else begin
               idx_d = idx_q;
            end
         end
         RUN:     idx_d = idx_q + IDX_W'(1'b1);
         DRAIN:   idx_d = idx_q;
         default: idx_d = {IDX_W{1'b0}};
      endcase
      // Results are taken from the next-state working values so the last score is included.
      if (state_q == DRAIN) begin
         max_idx_d = wmax_idx_d;
         max_val_d = wmax_val_d;
`ifdef ARGMAX_TOP2_EN
         sec_idx_d = wsec_idx_d;
         sec_val_d = wsec_val_d;
`else
         sec_idx_d = {IDX_W{1'b0}};
         sec_val_d = {DATA_W{1'b0}};
`endif
      end else begin
         max_idx_d = max_idx_q;
         max_val_d = max_val_q;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge CLK or negedge RESET_X) begin
      if (!RESET_X) begin
         idx_q      <= {IDX_W{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         max_idx_q  <= {IDX_W{1'b0}};
         max_val_q  <= {DATA_W{1'b0}};
         sec_idx_q  <= {IDX_W{1'b0}};
         sec_val_q  <= {DATA_W{1'b0}};
         wmax_idx_q <= {IDX_W{1'b0}};
         wmax_val_q <= {DATA_W{1'b0}};
      end else begin
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         max_idx_q  <= max_idx_d;
         max_val_q  <= max_val_d;
         sec_idx_q  <= sec_idx_d;
         sec_val_q  <= sec_val_d;
         wmax_idx_q <= wmax_idx_d;
         wmax_val_q <= wmax_val_d;
      end
   end

`ifdef ARGMAX_TOP2_EN
   // Runner-up working registers.
   always_ff @(posedge CLK or negedge RESET_X) begin
      if (!RESET_X) begin
         wsec_idx_q <= {IDX_W{1'b0}};
         wsec_val_q <= {DATA_W{1'b0}};
         wsec_vld_q <= 1'b0;
      end else begin
         wsec_idx_q <= wsec_idx_d;
         wsec_val_q <= wsec_val_d;
         wsec_vld_q <= wsec_vld_d;
      end
   end
`endif

   assign SCORE_IDX = idx_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign MAX_IDX   = max_idx_q;
   assign MAX_VAL   = max_val_q;
   assign SEC_IDX   = sec_idx_q;
   assign SEC_VAL   = sec_val_q;

endmodule

// File: tb/tb_score_argmax.sv
// Directed, table-driven bench for score_argmax (default 46-class build plus a 2-class build).
`timescale 1ns/1ps

module tb_score_argmax;

   localparam int NC = 46;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start2;
   logic [5:0]  score_idx, max_idx, sec_idx;
   logic [31:0] score, max_val, sec_val;
   logic        busy, done;
   logic [0:0]  score_idx2, max_idx2, sec_idx2;
   logic [31:0] score2, max_val2, sec_val2;
   logic        busy2, done2;
   logic [31:0] scores  [0:63];
   logic [31:0] scores2 [0:1];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          both_seen = 1'b0;

   typedef struct {
      int          kind;
      logic [5:0]  e_idx;
      logic [31:0] e_val;
      logic [5:0]  e_sidx;
      logic [31:0] e_sval;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   assign score  = scores[score_idx];
   assign score2 = scores2[score_idx2];

   score_argmax u_dut (
      .CLK(clk), .RESET_X(rst_n), .START(start), .SCORE_IDX(score_idx), .SCORE(score),
      .BUSY(busy), .DONE(done), .MAX_IDX(max_idx), .MAX_VAL(max_val),
      .SEC_IDX(sec_idx), .SEC_VAL(sec_val)
   );

   score_argmax #(.NUM_CLASS(2), .DATA_W(32), .IDX_W(1)) u_dut2 (
      .CLK(clk), .RESET_X(rst_n), .START(start2), .SCORE_IDX(score_idx2), .SCORE(score2),
      .BUSY(busy2), .DONE(done2), .MAX_IDX(max_idx2), .MAX_VAL(max_val2),
      .SEC_IDX(sec_idx2), .SEC_VAL(sec_val2)
   );

   always @(negedge clk) begin
      if ((busy && done) || (busy2 && done2)) both_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic load(input int kind);
      int v;
      for (int k = 0; k < 64; k++) begin
         case (kind)
            0:       v = k;
            1:       v = (k == 7) ? -3 : -100;
            2:       v = (k == 3 || k == 20) ? 500 : 0;
            3:       v = (k == 45) ? 32'sh7FFFFFFF : 32'sh80000000;
            default: v = 100 - k;
         endcase
         scores[k] = 32'(v);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int         lat;
      int         ndone;
      bit         held;
      logic [5:0] es_idx;
      logic [31:0] es_val;

      vecs[0] = '{0, 6'd45, 32'd45,         6'd44, 32'd44};
      vecs[1] = '{1, 6'd7,  32'hFFFFFFFD,   6'd0,  32'hFFFFFF9C};
      vecs[2] = '{2, 6'd3,  32'd500,        6'd20, 32'd500};
      vecs[3] = '{3, 6'd45, 32'h7FFFFFFF,   6'd0,  32'h80000000};
      vecs[4] = '{4, 6'd0,  32'd100,        6'd1,  32'd99};

      rst_n  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;
      load(0);
      scores2[0] = 32'd5;
      scores2[1] = 32'd9;
      #1;
      check("rst_score_idx", score_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_max_idx", max_idx, 0);
      check("rst_max_val", max_val, 0);
      check("rst_sec", {sec_idx, sec_val}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         load(vecs[i].kind);
`ifdef ARGMAX_TOP2_EN
         es_idx = vecs[i].e_sidx;
         es_val = vecs[i].e_sval;
`else
         es_idx = 6'd0;
         es_val = 32'd0;
`endif
         pulse_start();
         check($sformatf("v%0d_busy_start", i), busy, 1);
         check($sformatf("v%0d_idx_start", i), score_idx, 0);
         wait_done(lat);
         check($sformatf("v%0d_latency", i), lat, NC);
         check($sformatf("v%0d_max_idx", i), max_idx, vecs[i].e_idx);
         check($sformatf("v%0d_max_val", i), max_val, vecs[i].e_val);
         check($sformatf("v%0d_sec_idx", i), sec_idx, es_idx);
         check($sformatf("v%0d_sec_val", i), sec_val, es_val);
         check($sformatf("v%0d_busy_done", i), busy, 0);
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), done, 0);
         check($sformatf("v%0d_max_hold", i), max_val, vecs[i].e_val);
      end

      // START pulses while busy must be ignored.
      load(0);
      pulse_start();
      ndone = 0;
      lat   = 0;
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (lat == 0) lat = c;
         end
         start = (c == 5 || c == 20);
      end
      start = 1'b0;
      check("ign_start_ndone", ndone, 1);
      check("ign_start_latency", lat, NC);
      check("ign_start_max_idx", max_idx, 45);

      // START in the DONE cycle starts a back-to-back scan.
      load(1);
      pulse_start();
      wait_done(lat);
      check("b2b_first_max_idx", max_idx, 7);
      load(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", busy, 1);
      held = 1'b1;
      lat  = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         if (!done && max_idx != 6'd7) held = 1'b0;
      end
      check("b2b_held", held, 1);
      check("b2b_latency", lat, NC);
      check("b2b_max_idx", max_idx, 3);
      check("b2b_max_val", max_val, 500);

      // Reset in the middle of a scan.
      load(4);
      pulse_start();
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", {score_idx, busy, done, max_idx, max_val, sec_idx, sec_val}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("mid_rst_no_done", ndone, 0);
      pulse_start();
      wait_done(lat);
      check("post_rst_latency", lat, NC);
      check("post_rst_max", {max_idx, max_val}, {6'd0, 32'd100});

      // Two-class build.
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat = 0;
      while (!done2 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("nc2_latency", lat, 2);
      check("nc2_max_idx", max_idx2, 1);
      check("nc2_max_val", max_val2, 9);
`ifdef ARGMAX_TOP2_EN
      check("nc2_sec", {sec_idx2, sec_val2}, {1'b0, 32'd5});
`else
      check("nc2_sec", {sec_idx2, sec_val2}, 0);
`endif

      check("done_busy_exclusive", both_seen, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
